// File: rtl/gyro_bias_cal.sv
// Gyro bias calibration: averages 2^LOG2_SAMPLES stationary samples per axis, then subtracts
// the bias from each sample with saturation. Define GYRO_DEADBAND_EN to zero small residual rates.
module gyro_bias_cal #(
   parameter int LOG2_SAMPLES = 8,
   parameter int DEADBAND     = 4
) (
   input  logic        clk_100mhz,
   input  logic        rst_in,
   input  logic        recal_in,
   input  logic        raw_valid_in,
   input  logic [15:0] raw_gx_in,
   input  logic [15:0] raw_gy_in,
   input  logic [15:0] raw_gz_in,
   output logic [15:0] gx,
   output logic [15:0] gy,
   output logic [15:0] gz,
   output logic        valid_out,
   output logic        calibrated_out,
   output logic [0:0]  state_dbg
);

   localparam int AW = 16 + LOG2_SAMPLES;
   localparam logic [0:0] CAL = 1'b0;
   localparam logic [0:0] RUN = 1'b1;
   localparam logic signed [16:0] DB = 17'(DEADBAND);
`ifdef GYRO_DEADBAND_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif

   // Handshake: raw_valid_in is a one-cycle strobe with no backpressure; valid_out
   // pulses exactly one clock after each RUN-state sample and never otherwise.

   logic [0:0]              state;
   logic [LOG2_SAMPLES-1:0] cnt;
   logic signed [AW-1:0]    acc      [3];
   logic signed [AW-1:0]    acc_next [3];
   logic signed [15:0]      bias     [3];
   logic signed [15:0]      raw      [3];
   logic signed [15:0]      corr     [3];

   function automatic logic signed [15:0] condition(input logic signed [16:0] d);
      logic signed [15:0] s;
      if (d > 17'sd32767)
         s = 16'sh7fff;
      else if (d < -17'sd32768)
         s = 16'sh8000;
      else
         s = d[15:0];
      if (DB_EN && (17'(s) <= DB) && (17'(s) >= -DB))
         s = '0;
      return s;
   endfunction

   always_comb begin
      raw[0] = raw_gx_in;
      raw[1] = raw_gy_in;
      raw[2] = raw_gz_in;
      for (int i = 0; i < 3; i++) begin
         acc_next[i] = acc[i] + AW'(raw[i]);
         corr[i]     = condition(17'(raw[i]) - 17'(bias[i]));
      end
   end

   always_ff @(posedge clk_100mhz or posedge rst_in) begin
      if (rst_in) begin
         state     <= CAL;
         cnt       <= '0;
         valid_out <= 1'b0;
         gx        <= '0;
         gy        <= '0;
         gz        <= '0;
         for (int i = 0; i < 3; i++) begin
            acc[i]  <= '0;
            bias[i] <= '0;
         end
      end else if (recal_in) begin
         // Bias is deliberately retained; it is only replaced when the new average completes.
         state     <= CAL;
         cnt       <= '0;
         valid_out <= 1'b0;
         gx        <= '0;
         gy        <= '0;
         gz        <= '0;
         for (int i = 0; i < 3; i++) acc[i] <= '0;
      end else begin
         valid_out <= 1'b0;
         if (raw_valid_in) begin
            if (state == CAL) begin
               cnt <= cnt + 1'b1;
               if (&cnt) begin
                  // Arithmetic shift of the final sum: floor division toward -inf.
                  state <= RUN;
                  for (int i = 0; i < 3; i++) begin
                     bias[i] <= acc_next[i][AW-1:LOG2_SAMPLES];
                     acc[i]  <= '0;
                  end
               end else begin
                  for (int i = 0; i < 3; i++) acc[i] <= acc_next[i];
               end
            end else begin
               gx        <= corr[0];
               gy        <= corr[1];
               gz        <= corr[2];
               valid_out <= 1'b1;
            end
         end
      end
   end

   assign calibrated_out = (state == RUN);
   assign state_dbg      = state;

endmodule

// File: doc/gyro_bias_cal.md
Name: gyro_bias_cal

Overview:
- Conditions raw signed gyro rate samples before the integrator stage (process_gyro_simple) that builds pitch/roll/yaw.
- After reset or a recalibration request, averages 2^LOG2_SAMPLES stationary samples per axis to estimate zero-rate bias.
- Thereafter subtracts the bias from every sample and drives saturated 16-bit signed gx/gy/gz with a valid strobe to the integrator.

Parameters:
LOG2_SAMPLES, 8, log2 of calibration sample count (256 samples); legal range 1..12
DEADBAND, 4, magnitude (LSB) at or below which corrected rates are zeroed (only with GYRO_DEADBAND_EN)

Ports:
clk_100mhz  input  1  system clock, all logic on rising edge
rst_in  input  1  asynchronous active-high reset
recal_in  input  1  single-cycle request to restart calibration
raw_valid_in  input  1  raw sample strobe, one cycle per sample
raw_gx_in  input  16  raw X rate, two's complement
raw_gy_in  input  16  raw Y rate, two's complement
raw_gz_in  input  16  raw Z rate, two's complement
gx  output  16  bias-corrected X rate, signed
gy  output  16  bias-corrected Y rate, signed
gz  output  16  bias-corrected Z rate, signed
valid_out  output  1  one-cycle strobe, gx/gy/gz updated this cycle
calibrated_out  output  1  high once the bias is valid (RUN state)

Behaviour:
- Reset (async assert, sync release): state CAL; accumulators, sample counter, biases = 0; gx/gy/gz = 0; valid_out = 0; calibrated_out = 0.
- States: CAL, RUN.
- CAL:
  - Each raw_valid_in adds the sign-extended sample into a per-axis signed accumulator of width 16+LOG2_SAMPLES, so no overflow is possible, and increments the counter.
  - On the cycle the 2^LOG2_SAMPLES-th sample is accepted:
    - bias = (acc + sample) >>> LOG2_SAMPLES, arithmetic shift, truncation toward -inf.
    - State goes to RUN; calibrated_out goes high on the next edge.
  - During CAL: valid_out = 0; gx/gy/gz held at 0.
- RUN:
  - Each raw_valid_in computes diff = raw - bias at 17-bit signed width.
  - diff is clamped to [-32768, 32767] and registered to gx/gy/gz.
  - valid_out = 1 on the following cycle. Latency is exactly 1 clock; valid_out is never high two cycles in a row unless raw_valid_in was.
  - Without raw_valid_in, outputs hold their last value and valid_out = 0.
  - Back-to-back raw_valid_in every cycle is supported at full rate.
- Calibration samples are never forwarded. The calibrating sample itself produces no valid_out.
- recal_in in any state:
  - Clears the accumulators and counter and enters CAL next cycle.
  - calibrated_out, gx/gy/gz and valid_out go to 0 next cycle.
  - Old biases are kept until the new calibration completes (observable only via outputs after completion).
- recal_in together with raw_valid_in: recal wins and the sample is discarded (not counted, not output).
- recal_in during CAL restarts the count from 0.
- Reset mid-operation behaves as a fresh reset; no partial state survives.

Optional Feature:
- Macro: GYRO_DEADBAND_EN.
- Defined: in RUN, after saturation, any axis with |diff| <= DEADBAND outputs 0. This suppresses integrator drift from residual noise. Applies per axis; valid_out timing is unchanged.
- Undefined: no deadband; DEADBAND is unused; the output is the saturated difference only.

Test Plan:
- Reset, LOG2_SAMPLES=2, feed four samples gx=10,12,14,16 (gy=0, gz=-8 each) -> calibrated_out rises 1 cycle after the 4th sample; bias x=13, z=-8; no valid_out during CAL.
- After that calibration, raw gx=113, gy=5, gz=-8 -> one cycle later valid_out=1, gx=100, gy=5, gz=0; the next cycle valid_out=0 and values hold.
- Bias x=-100 (calibrate on -100), raw gx=32700 -> gx=32767 saturated; bias x=+100, raw gx=-32700 -> gx=-32768.
- In RUN, pulse recal_in concurrent with raw_valid_in -> no valid_out; calibrated_out=0 and gx/gy/gz=0 next cycle; recalibration needs 4 fresh samples.
- Negative truncation: samples -1,-1,-1,-2 (LOG2=2) -> bias = -5>>>2 = -2; raw -2 -> gx=0.
- With GYRO_DEADBAND_EN, DEADBAND=4, bias 0: raw gx=4, gy=-4, gz=5 -> gx=0, gy=0, gz=5; without the macro -> 4, -4, 5.
